// File: rtl/mips_lsu_if.sv
// Request, data-memory and writeback signals of the MIPS load/store unit.
// Handshake: a request transfers on a rising edge with req_valid && req_ready; the requester holds its fields stable until then.
interface mips_lsu_if;
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [4:0]      req_rd;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_out;
  logic [0:3][7:0] mem_data_in;
  logic            mem_write_en;
  logic [4:0]      rd_num;
  logic [31:0]     rd_data;
  logic            rd_we;
  logic            done;
  logic            misalign;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, mem_data_out,
    input  req_ready, mem_addr, mem_data_in, mem_write_en, rd_num, rd_data, rd_we, done, misalign
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, mem_data_out,
    output req_ready, mem_addr, mem_data_in, mem_write_en, rd_num, rd_data, rd_we, done, misalign
  );
endinterface

// File: rtl/mips_lsu.sv
// Single-request load/store unit; sub-word stores are read-modify-write on a word-wide memory port.
// Optional macro LSU_MISALIGN_TRAP_EN: reject misaligned requests instead of forcing alignment.
module mips_lsu #(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_b,
  mips_lsu_if.slave  bus,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WB    = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t          state;
  state_t          accept_state;
  logic [3:0]      cnt;
  logic [3:0]      op_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [4:0]      rd_q;
  logic [0:3][7:0] buf_q;

  logic [1:0]      size_in;
  logic [XLEN-1:0] addr_in;
  logic [XLEN-1:0] load_val;
  logic [7:0]      lane_b;
  logic [15:0]     half_v;
  logic [0:3][7:0] wr_lanes;

  assign size_in   = bus.req_op[1:0];
  assign state_dbg = state;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_in;
  assign misaligned_in = (size_in == 2'b01 && bus.req_addr[0]) ||
                         (size_in == 2'b10 && bus.req_addr[1:0] != 2'b00);
  assign addr_in = bus.req_addr;
`else
  // Without the trap, the low address bits are silently dropped to the access size.
  always_comb begin
    addr_in = bus.req_addr;
    if (size_in == 2'b10)      addr_in[1:0] = 2'b00;
    else if (size_in == 2'b01) addr_in[0]   = 1'b0;
  end
`endif

  always_comb begin
    accept_state = READ;
    if (size_in == 2'b11)                          accept_state = WB;
    else if (bus.req_op[3] && size_in == 2'b10)    accept_state = WRITE;
`ifdef LSU_MISALIGN_TRAP_EN
    if (misaligned_in)                             accept_state = FAULT;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      buf_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            addr_q  <= addr_in;
            wdata_q <= bus.req_wdata;
            rd_q    <= bus.req_rd;
            cnt     <= 4'd1;
            state   <= accept_state;
          end
        end
        READ: begin
          if (cnt == 4'(MEM_LAT)) begin
            buf_q <= bus.mem_data_out;
            state <= op_q[3] ? WRITE : WB;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane 0 is the most significant byte, so packed [0:3] indexing matches byte offset.
  always_comb begin
    lane_b   = buf_q[addr_q[1:0]];
    half_v   = {buf_q[{addr_q[1], 1'b0}], buf_q[{addr_q[1], 1'b1}]};
    load_val = '0;
    case (op_q[1:0])
      2'b00:   load_val = op_q[2] ? {{(XLEN-8){1'b0}}, lane_b} : {{(XLEN-8){lane_b[7]}}, lane_b};
      2'b01:   load_val = op_q[2] ? {{(XLEN-16){1'b0}}, half_v} : {{(XLEN-16){half_v[15]}}, half_v};
      2'b10:   load_val = buf_q;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    wr_lanes = buf_q;
    case (op_q[1:0])
      2'b00: wr_lanes[addr_q[1:0]] = wdata_q[7:0];
      2'b01: begin
        wr_lanes[{addr_q[1], 1'b0}] = wdata_q[15:8];
        wr_lanes[{addr_q[1], 1'b1}] = wdata_q[7:0];
      end
      default: wr_lanes = wdata_q;
    endcase
  end

  // Every output is held at zero while reset is asserted, so a WRITE cycle hit by reset commits nothing.
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_data_in  = '0;
    bus.mem_write_en = 1'b0;
    bus.rd_num       = '0;
    bus.rd_data      = '0;
    bus.rd_we        = 1'b0;
    bus.done         = 1'b0;
    bus.misalign     = 1'b0;
    if (!rst_b) begin
      case (state)
        IDLE: bus.req_ready = 1'b1;
        READ: bus.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        WRITE: begin
          bus.mem_addr     = {addr_q[XLEN-1:2], 2'b00};
          bus.mem_data_in  = wr_lanes;
          bus.mem_write_en = 1'b1;
          bus.done         = 1'b1;
        end
        WB: begin
          bus.mem_addr = {addr_q[XLEN-1:2], 2'b00};
          bus.rd_num   = rd_q;
          bus.rd_data  = load_val;
          bus.rd_we    = (rd_q != 5'd0) && (op_q[1:0] != 2'b11);
          bus.done     = 1'b1;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        FAULT: bus.misalign = 1'b1;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit for the MIPS core. It accepts one memory request at a time from the execute stage and drives the core's byte-lane data memory port. Loads are extracted, extended and written back through the register-file write port (rd_num/rd_data/rd_we). Byte and halfword stores are performed as read-modify-write, because the memory port has a single write enable.

## Interface
- XLEN, 32, data/address width; only 32 is supported.
- MEM_LAT, 2, cycles mem_addr must be held before mem_data_out is valid; legal range 1..15.

- clk  input  1  clock; all state changes on the rising edge.
- rst_b  input  1  reset; synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle; a request is accepted when req_valid && req_ready at a rising edge.
- req_op  input  4  [3] store, [2] unsigned (loads only), [1:0] size: 00 byte, 01 half, 10 word, 11 reserved.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- req_rd  input  5  load destination register.
- mem_addr  output  32  word address, with bits [1:0] always 0.
- mem_data_out  input  8x[0:3]  read lanes, big-endian: lane 0 is the byte at word+0, which is the MSB.
- mem_data_in  output  8x[0:3]  write lanes, same ordering.
- mem_write_en  output  1  writes all four lanes at the rising edge.
- rd_num  output  5  writeback register.
- rd_data  output  32  writeback data.
- rd_we  output  1  writeback strobe.
- done  output  1  one-cycle pulse when a request completes.
- misalign  output  1  one-cycle pulse when a request is rejected.

## Operation
- States:
  - IDLE: req_ready=1.
  - READ: counter counts 1..MEM_LAT.
  - WRITE
  - WB
  - FAULT
- Request fields are latched on accept.
- Alignment rule: half needs addr[0]=0; word needs addr[1:0]=0.
- Transitions from IDLE on accept:
  - Misaligned → FAULT.
  - Size 11 → WB with rd_we forced 0 (no-op).
  - SW → WRITE.
  - Any load, SB or SH → READ.
- READ:
  - mem_addr = {addr[31:2],2'b00}.
  - mem_data_out is captured into a word buffer on the cycle where the counter equals MEM_LAT.
  - Then: loads → WB; SB/SH → WRITE.
- Load extraction:
  - Byte = lane addr[1:0].
  - Half = {lane 2·addr[1], lane 2·addr[1]+1}.
  - Word = {lane0..lane3}.
  - Signed loads sign-extend; unsigned loads zero-extend.
- WB:
  - rd_we=1 and done=1 for one cycle.
  - If rd=0: rd_we=0, done=1.
- WRITE: mem_write_en=1 and done=1 for one cycle.
  - SW: lanes = wdata[31:24],[23:16],[15:8],[7:0].
  - SB: buffer with lane addr[1:0] replaced by wdata[7:0].
  - SH: buffer with lanes 2a,2a+1 replaced by wdata[15:8],wdata[7:0], where a=addr[1].
- FAULT: misalign=1 for one cycle. No memory access and no writeback.
- Every non-IDLE state returns to IDLE after its final cycle. Requests are never pipelined.
- Idle output values:
  - mem_addr=0, mem_data_in=0, rd_num=0, rd_data=0 whenever not in READ/WRITE/WB.
  - mem_write_en, rd_we, done, misalign are 0 outside their states.

## Timing
- Request accepted at the end of cycle T.
- SW: WRITE in cycle T+1.
- Loads: READ in cycles T+1..T+MEM_LAT; WB in cycle T+MEM_LAT+1.
- SB/SH: READ as for loads; WRITE in cycle T+MEM_LAT+1.
- FAULT and no-op: cycle T+1.
- Earliest next accept is the cycle after done or misalign, because req_ready is 1 only in IDLE.
- req_ready deasserts in the cycle after an accept (T+1).
- Reset:
  - rst_b sampled high forces IDLE and clears the counter, buffer and latched request.
  - All outputs are 0 while rst_b is high, including req_ready.
  - mem_write_en is gated by !rst_b, so a WRITE coinciding with reset commits nothing.
  - req_ready=1 in the first cycle after rst_b falls.
- Reset mid-READ abandons the request with no done pulse.
- req_valid while busy is ignored; the requester must hold it until accepted.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned requests go to FAULT as above.
- LSU_MISALIGN_TRAP_EN undefined:
  - misalign is tied to 0.
  - Low address bits are forced to alignment on accept: addr[0]=0 for half, addr[1:0]=0 for word.
  - The request then proceeds normally.

## Test plan
- Word load:
  - Stimulus: MEM_LAT=2; word 0x100 holds DE,AD,BE,EF; LW 0x100 with rd=5 accepted at T.
  - Required: mem_addr=0x100 in T+1..T+2; at T+3 rd_we=1, rd_num=5, rd_data=0xDEADBEEF, done=1.
- Sub-word loads from the same word:
  - LB 0x101 → 0xFFFFFFAD.
  - LBU 0x101 → 0x000000AD.
  - LH 0x102 → 0xFFFFBEEF.
  - LHU 0x102 → 0x0000BEEF.
- Byte store:
  - Stimulus: SB 0x103 with wdata=0x12 on the word above.
  - Required: at T+3 only, mem_write_en=1 with lanes DE,AD,BE,12; a following LW 0x100 returns 0xDEADBE12.
- Word store:
  - Stimulus: SW 0x200 with wdata=0xCAFEF00D.
  - Required: mem_write_en=1 only at T+1, lanes CA,FE,F0,0D, done=1; req_ready=1 at T+2.
- Misaligned halfword load, LH 0x101:
  - Macro defined: misalign=1 at T+1; no rd_we, no mem_write_en, no done.
  - Macro undefined: reads word 0x100 and returns 0xFFFFDEAD.
- Reset and rd=0:
  - Stimulus: rst_b high for one cycle during the READ of an SH.
  - Required: no write occurs, no done pulse, req_ready=1 the cycle after reset.
  - Stimulus: LW with rd=0.
  - Required: done=1 with rd_we=0.
